// File: rtl/program_loader_ctrl.sv
// program_loader_ctrl: copies a program image from host memory into the
// Briey core RAM, one 64-byte line at a time. Each line is one AXI read
// (single-beat burst) followed by one program-load write. The core is held
// in reset for the whole load. It is released only after the load enable
// has dropped.
module program_loader_ctrl #(
  parameter int          RAM_ADDR_WIDTH = 15,
  parameter int          LEN_WIDTH      = 16,
  parameter logic [11:0] AXI_ID         = 12'h000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [63:0]               host_base,
  input  logic [RAM_ADDR_WIDTH-1:0] ram_base,
  input  logic [LEN_WIDTH-1:0]      num_lines,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [LEN_WIDTH-1:0]      lines_done,
  output logic                      core_reset,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [63:0]               araddr,
  output logic [11:0]               arid,
  output logic [9:0]                arlen,
  output logic [2:0]                arsize,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [511:0]              rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic [11:0]               rid,
  output logic                      program_load_en,
  output logic                      program_load_aw_valid,
  input  logic                      program_load_aw_ready,
  output logic [RAM_ADDR_WIDTH-1:0] program_load_aw_payload_addr,
  output logic                      program_load_w_valid,
  input  logic                      program_load_w_ready,
  output logic [511:0]              program_load_w_payload_data,
  output logic [63:0]               program_load_w_payload_strb
);

  typedef enum logic [2:0] {IDLE, AR, R, WR, FIN} state_t;

  localparam logic [63:0]               HOST_LINE = 64'd64;
  localparam logic [RAM_ADDR_WIDTH-1:0] RAM_LINE  = RAM_ADDR_WIDTH'(64);

  state_t                    state_q, state_n;
  logic                      arvalid_q, arvalid_n;
  logic                      rready_q, rready_n;
  logic                      aw_valid_q, aw_valid_n;
  logic                      w_valid_q, w_valid_n;
  logic                      aw_done_q, aw_done_n;
  logic                      w_done_q, w_done_n;
  logic                      load_en_q, load_en_n;
  logic                      core_reset_q, core_reset_n;
  logic                      busy_q, busy_n;
  logic                      done_q, done_n;
  logic                      error_q, error_n;
  logic [LEN_WIDTH-1:0]      idx_q, idx_n;
  logic [LEN_WIDTH-1:0]      num_q, num_n;
  logic [63:0]               host_addr_q, host_addr_n;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_n;
  logic [511:0]              line_buf_q, line_buf_n;

  logic aw_hs, w_hs, aw_ok, w_ok;
  logic unused_inputs;

  // rid and rlast carry no information with a single outstanding single-beat read.
  assign unused_inputs = ^{rid, rlast};

  assign aw_hs = aw_valid_q & program_load_aw_ready;
  assign w_hs  = w_valid_q & program_load_w_ready;
  assign aw_ok = aw_done_q | aw_hs;
  assign w_ok  = w_done_q | w_hs;

  // State register and all registered outputs; reset parks the core in reset with the buses quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      load_en_q    <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      idx_q        <= '0;
      num_q        <= '0;
      host_addr_q  <= '0;
      ram_addr_q   <= '0;
      line_buf_q   <= '0;
    end else begin
      state_q      <= state_n;
      arvalid_q    <= arvalid_n;
      rready_q     <= rready_n;
      aw_valid_q   <= aw_valid_n;
      w_valid_q    <= w_valid_n;
      aw_done_q    <= aw_done_n;
      w_done_q     <= w_done_n;
      load_en_q    <= load_en_n;
      core_reset_q <= core_reset_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      error_q      <= error_n;
      idx_q        <= idx_n;
      num_q        <= num_n;
      host_addr_q  <= host_addr_n;
      ram_addr_q   <= ram_addr_n;
      line_buf_q   <= line_buf_n;
    end
  end

  // Next-state and next-output logic; running host/RAM addresses advance by one line per completed write.
  always_comb begin
    state_n      = state_q;
    arvalid_n    = arvalid_q;
    rready_n     = rready_q;
    aw_valid_n   = aw_valid_q;
    w_valid_n    = w_valid_q;
    aw_done_n    = aw_done_q;
    w_done_n     = w_done_q;
    load_en_n    = load_en_q;
    core_reset_n = core_reset_q;
    busy_n       = busy_q;
    done_n       = 1'b0;
    error_n      = error_q;
    idx_n        = idx_q;
    num_n        = num_q;
    host_addr_n  = host_addr_q;
    ram_addr_n   = ram_addr_q;
    line_buf_n   = line_buf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          error_n      = 1'b0;
          idx_n        = '0;
          num_n        = num_lines;
          host_addr_n  = host_base;
          ram_addr_n   = ram_base;
          core_reset_n = 1'b1;
          busy_n       = 1'b1;
          if (num_lines != '0) begin
            load_en_n = 1'b1;
            arvalid_n = 1'b1;
            state_n   = AR;
          end else begin
            load_en_n = 1'b0;
            done_n    = 1'b1;
            state_n   = FIN;
          end
        end
      end

      AR: begin
        if (arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = R;
        end
      end

      R: begin
        if (rvalid) begin
          rready_n = 1'b0;
          if (rresp == 2'b00) begin
            line_buf_n = rdata;
            aw_valid_n = 1'b1;
            w_valid_n  = 1'b1;
            state_n    = WR;
          end else begin
            error_n   = 1'b1;
            load_en_n = 1'b0;
            busy_n    = 1'b0;
            state_n   = IDLE;
          end
        end
      end

      WR: begin
        if (aw_hs) begin
          aw_valid_n = 1'b0;
          aw_done_n  = 1'b1;
        end
        if (w_hs) begin
          w_valid_n = 1'b0;
          w_done_n  = 1'b1;
        end
        if (aw_ok && w_ok) begin
          aw_done_n   = 1'b0;
          w_done_n    = 1'b0;
          idx_n       = idx_q + LEN_WIDTH'(1);
          host_addr_n = host_addr_q + HOST_LINE;
          ram_addr_n  = ram_addr_q + RAM_LINE;
          if (idx_q + LEN_WIDTH'(1) == num_q) begin
            load_en_n = 1'b0;
            done_n    = 1'b1;
            state_n   = FIN;
          end else begin
            arvalid_n = 1'b1;
            state_n   = AR;
          end
        end
      end

      FIN: begin
        core_reset_n = 1'b0;
        busy_n       = 1'b0;
        state_n      = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy                         = busy_q;
  assign done                         = done_q;
  assign error                        = error_q;
  assign lines_done                   = idx_q;
  assign core_reset                   = core_reset_q;
  assign arvalid                      = arvalid_q;
  assign araddr                       = host_addr_q;
  assign arid                         = AXI_ID;
  assign arlen                        = 10'd0;
  assign arsize                       = 3'b110;
  assign rready                       = rready_q;
  assign program_load_en              = load_en_q;
  assign program_load_aw_valid        = aw_valid_q;
  assign program_load_aw_payload_addr = ram_addr_q;
  assign program_load_w_valid         = w_valid_q;
  assign program_load_w_payload_data  = line_buf_q;
  assign program_load_w_payload_strb  = {64{1'b1}};

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Testbench for program_loader_ctrl: acts as the AXI read slave and the
// program-load sink. Every write is compared against a model of host memory.
module tb_program_loader_ctrl;

  localparam int RAW = 15;
  localparam int LW  = 16;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [63:0]    host_base;
  logic [RAW-1:0] ram_base;
  logic [LW-1:0]  num_lines;
  logic           busy, done, error;
  logic [LW-1:0]  lines_done;
  logic           core_reset;
  logic           arvalid, arready;
  logic [63:0]    araddr;
  logic [11:0]    arid;
  logic [9:0]     arlen;
  logic [2:0]     arsize;
  logic           rvalid, rready;
  logic [511:0]   rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic [11:0]    rid;
  logic           program_load_en;
  logic           aw_valid, aw_ready;
  logic [RAW-1:0] aw_addr;
  logic           w_valid, w_ready;
  logic [511:0]   w_data;
  logic [63:0]    w_strb;

  program_loader_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .host_base(host_base), .ram_base(ram_base), .num_lines(num_lines),
    .busy(busy), .done(done), .error(error), .lines_done(lines_done),
    .core_reset(core_reset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid),
    .program_load_en(program_load_en),
    .program_load_aw_valid(aw_valid), .program_load_aw_ready(aw_ready),
    .program_load_aw_payload_addr(aw_addr),
    .program_load_w_valid(w_valid), .program_load_w_ready(w_ready),
    .program_load_w_payload_data(w_data),
    .program_load_w_payload_strb(w_strb)
  );

  always #5 clk = ~clk;

  int             vectorCount = 0;
  int             miscompareCount = 0;
  int             cyc;
  logic [31:0]    dataSeed;
  logic [63:0]    curHost;
  logic [RAW-1:0] curRam;
  int             curN;
  bit             fastMode;
  int             errLine;
  int             arCount, pairCount, pendIdx, wWait;
  bit             pendValid;
  logic [63:0]    pendAddr;
  logic [RAW-1:0] awQ[$];
  logic [511:0]   wQ[$];
  bit             prevArStall, prevAwStall, prevWStall;
  logic [63:0]    prevAraddr;
  logic [RAW-1:0] prevAwAddr;
  logic [511:0]   prevWData;

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectorCount++;
    if (got !== exp) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host memory model: contents are a pure function of the line address.
  function automatic logic [511:0] lineData(input logic [63:0] addr);
    logic [511:0] v;
    logic [31:0]  lineNo;
    lineNo = addr[37:6];
    for (int k = 0; k < 16; k++)
      v[k*32 +: 32] = (lineNo * 32'h9E37_79B1) ^ (addr[63:32] + 32'(k) * 32'h0100_0193) ^ dataSeed;
    return v;
  endfunction

  function automatic logic [RAW-1:0] expRam(input int i);
    int t;
    t = int'(curRam) + 64 * i;
    return t[RAW-1:0];
  endfunction

  function automatic logic [63:0] expHost(input int i);
    return curHost + 64'(i) * 64'd64;
  endfunction

  task automatic driveInputs();
    arready = fastMode ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (pendValid && (fastMode || $urandom_range(0, 1) == 1)) begin
      rvalid = 1'b1;
      rdata  = lineData(pendAddr);
      rresp  = (pendIdx == errLine) ? 2'b10 : 2'b00;
      rlast  = 1'b1;
      rid    = 12'($urandom);
    end else begin
      rvalid = 1'b0;
      rdata  = {16{$urandom}};
      rresp  = 2'($urandom);
      rlast  = 1'($urandom);
      rid    = 12'($urandom);
    end
    if (fastMode) begin
      aw_ready = 1'b1;
      w_ready  = 1'b1;
    end else if (pairCount == 1) begin
      aw_ready = 1'b1;
      w_ready  = (wWait >= 4);
    end else begin
      aw_ready = 1'($urandom_range(0, 1));
      w_ready  = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock: record handshakes seen before the edge, then check the new outputs.
  task automatic tick();
    logic           arHs, rHs, awHs, wHs, rstEdge;
    logic [RAW-1:0] a;
    logic [511:0]   d;
    arHs    = arvalid & arready;
    rHs     = rvalid & rready;
    awHs    = aw_valid & aw_ready;
    wHs     = w_valid & w_ready;
    rstEdge = rst;
    prevArStall = arvalid & ~arready;
    prevAraddr  = araddr;
    prevAwStall = aw_valid & ~aw_ready;
    prevAwAddr  = aw_addr;
    prevWStall  = w_valid & ~w_ready;
    prevWData   = w_data;
    if (arHs) begin
      checkOutput("araddr", 512'(araddr), 512'(expHost(arCount)));
      checkOutput("ar_consts", 512'({arid, arlen, arsize}), 512'({12'h000, 10'd0, 3'b110}));
      pendValid = 1'b1;
      pendAddr  = expHost(arCount);
      pendIdx   = arCount;
      arCount++;
    end
    if (rHs) pendValid = 1'b0;
    if (awHs) awQ.push_back(aw_addr);
    if (wHs) begin
      wQ.push_back(w_data);
      checkOutput("w_strb", 512'(w_strb), 512'({64{1'b1}}));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    while (awQ.size() > 0 && wQ.size() > 0) begin
      a = awQ.pop_front();
      d = wQ.pop_front();
      checkOutput("aw_addr", 512'(a), 512'(expRam(pairCount)));
      checkOutput("w_data", d, lineData(expHost(pairCount)));
      pairCount++;
    end
    if (!rstEdge) begin
      if (prevArStall) checkOutput("ar_hold", 512'({arvalid, araddr}), 512'({1'b1, prevAraddr}));
      if (prevAwStall) checkOutput("aw_hold", 512'({aw_valid, aw_addr}), 512'({1'b1, prevAwAddr}));
      if (prevWStall)  checkOutput("w_hold", 512'({w_valid, w_data}), 512'({1'b1, prevWData}));
    end
    checkOutput("en_needs_core_reset", 512'(program_load_en & ~core_reset), 512'(0));
    if (w_valid) wWait++;
    else wWait = 0;
    driveInputs();
  endtask

  // Runs one load request from start to completion, error abort or injected reset.
  task automatic applyStimulus(input logic [63:0] hb, input logic [RAW-1:0] rb, input int n,
                               input bit fast, input int errL, input bit holdStart,
                               input bit abortOnWrite);
    bit finished;
    finished    = 1'b0;
    curHost     = hb;
    curRam      = rb;
    curN        = n;
    fastMode    = fast;
    errLine     = errL;
    arCount     = 0;
    pairCount   = 0;
    pendValid   = 1'b0;
    wWait       = 0;
    prevArStall = 1'b0;
    prevAwStall = 1'b0;
    prevWStall  = 1'b0;
    awQ.delete();
    wQ.delete();
    host_base = hb;
    ram_base  = rb;
    num_lines = LW'(n);
    start     = 1'b1;
    cyc       = 0;
    driveInputs();
    for (int guard = 0; guard < 4000 && !finished; guard++) begin
      tick();
      if (cyc == 1) checkOutput("error_cleared", 512'(error), 512'(0));
      if (abortOnWrite && w_valid) begin
        rst = 1'b1; arready = 1'b0; rvalid = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_abort",
                    512'({arvalid, rready, aw_valid, w_valid, program_load_en, busy, done, core_reset}),
                    512'(8'b0000_0001));
        checkOutput("reset_abort_count", 512'(lines_done), 512'(0));
        rst = 1'b0;
        start = 1'b0;
        pendValid = 1'b0;
        prevArStall = 1'b0;
        prevAwStall = 1'b0;
        prevWStall = 1'b0;
        tick();
        checkOutput("reset_stays_idle", 512'({busy, arvalid, core_reset}), 512'(3'b001));
        finished = 1'b1;
      end else begin
        if (fast && errL < 0) begin
          checkOutput("done_timing", 512'(done), 512'(cyc == 3 * n + 1));
          checkOutput("busy_window", 512'(busy), 512'(1));
        end else if (errL < 0) begin
          checkOutput("busy_slow", 512'(busy), 512'(1));
        end
        if (done) begin
          start = 1'b0;
          checkOutput("done_outputs", 512'({program_load_en, core_reset, busy, arvalid, aw_valid}),
                      512'(5'b01100));
          checkOutput("done_lines", 512'(lines_done), 512'(n));
          checkOutput("done_writes", 512'(pairCount), 512'(n));
          checkOutput("done_reads", 512'(arCount), 512'(n));
          tick();
          checkOutput("core_release", 512'({core_reset, busy, done, program_load_en}), 512'(0));
          finished = 1'b1;
        end else if (!busy) begin
          start = 1'b0;
          checkOutput("abort_error_flag", 512'(error), 512'(errL >= 0));
          checkOutput("abort_outputs", 512'({program_load_en, core_reset, done}), 512'(3'b010));
          checkOutput("abort_lines_done", 512'(lines_done), 512'(errL >= 0 ? errL : n));
          checkOutput("abort_writes", 512'(pairCount), 512'(errL >= 0 ? errL : n));
          finished = 1'b1;
        end else begin
          start = holdStart ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
    end
    checkOutput("load_finished", 512'(finished), 512'(1));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0]    rhb;
    logic [RAW-1:0] rrb;
    rst = 1'b1; start = 1'b0; host_base = '0; ram_base = '0; num_lines = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    aw_ready = 1'b0; w_ready = 1'b0;
    dataSeed = $urandom;
    fastMode = 1'b1;
    errLine  = -1;
    repeat (3) @(negedge clk);
    checkOutput("reset_values",
                512'({arvalid, rready, aw_valid, w_valid, program_load_en, busy, done, error, core_reset}),
                512'(9'b0_0000_0001));
    checkOutput("reset_lines_done", 512'(lines_done), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", 512'({busy, core_reset}), 512'(2'b01));

    $display("[TB] single line, readies high");
    applyStimulus(64'h1000, 15'h0040, 1, 1'b1, -1, 1'b0, 1'b0);
    $display("[TB] four lines with stalls");
    applyStimulus(64'h0, 15'h0000, 4, 1'b0, -1, 1'b0, 1'b0);
    $display("[TB] read error on line 1 of 3");
    applyStimulus(64'h2000, 15'h0100, 3, 1'b0, 1, 1'b0, 1'b0);
    $display("[TB] next start clears error");
    applyStimulus(64'h3000, 15'h0000, 1, 1'b1, -1, 1'b0, 1'b0);
    $display("[TB] zero-line load");
    applyStimulus(64'h4000, 15'h0200, 0, 1'b1, -1, 1'b0, 1'b0);
    $display("[TB] RAM address wrap");
    applyStimulus(64'h5000, 15'h7FC0, 2, 1'b1, -1, 1'b0, 1'b0);
    $display("[TB] start held high while busy");
    applyStimulus(64'h0000_0001_0000_0040, 15'h1000, 2, 1'b1, -1, 1'b1, 1'b0);
    $display("[TB] reset during write");
    applyStimulus(64'h6000, 15'h0000, 3, 1'b1, -1, 1'b1, 1'b1);

    $display("[TB] randomized loads");
    for (int k = 0; k < 6; k++) begin
      rhb = {$urandom, $urandom};
      rhb[5:0] = 6'd0;
      if (k == 0) rhb = 64'hFFFF_FFFF_FFFF_FF80;
      rrb = RAW'($urandom);
      rrb[5:0] = 6'd0;
      applyStimulus(rhb, rrb, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), -1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/program_loader_ctrl.md
# program_loader_ctrl

Sequences loading a RISC-V program image from host memory into the Briey core RAM. On `start` it fetches `num_lines` 64-byte lines from host memory over the AXI-MM read channels (single-beat bursts). It writes each line into core RAM through the `program_load_*` port, holding `program_load_en` and core reset asserted throughout. When the load finishes it drops `program_load_en` first, then releases core reset. It sits between the host-facing AXI-MM master read channels and the Briey wrapper's program-load inputs.

## Interface
- `RAM_ADDR_WIDTH`, 15: core RAM byte-address width.
- `LEN_WIDTH`, 16: width of the line count.
- `AXI_ID`, 12'h000: constant `arid` value.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  load request; sampled only in IDLE.
- `host_base`  in  64  host byte address of line 0; bits [5:0] must be 0.
- `ram_base`  in  RAM_ADDR_WIDTH  core RAM byte address of line 0; bits [5:0] must be 0.
- `num_lines`  in  LEN_WIDTH  number of 64B lines to copy.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky; cleared by the next accepted `start`.
- `lines_done`  out  LEN_WIDTH  count of lines fully written.
- `core_reset`  out  1  held-reset request to the RISC-V core.
- `arvalid`  out  1  AXI read address valid.
- `arready`  in  1  AXI read address ready.
- `araddr`  out  64  AXI read address.
- `arid`  out  12  AXI read ID.
- `arlen`  out  10  AXI burst length.
- `arsize`  out  3  AXI burst size.
- `rvalid`  in  1  AXI read data valid.
- `rready`  out  1  AXI read data ready.
- `rdata`  in  512  AXI read data.
- `rresp`  in  2  AXI read response.
- `rlast`  in  1  AXI last beat.
- `rid`  in  12  AXI read ID.
- `program_load_en`  out  1  RAM reload enable.
- `program_load_aw_valid`  out  1  program-load address valid.
- `program_load_aw_ready`  in  1  program-load address ready.
- `program_load_aw_payload_addr`  out  RAM_ADDR_WIDTH  program-load byte address.
- `program_load_w_valid`  out  1  program-load data valid.
- `program_load_w_ready`  in  1  program-load data ready.
- `program_load_w_payload_data`  out  512  program-load data.
- `program_load_w_payload_strb`  out  64  program-load byte strobes.

## Operation
- States: IDLE, AR, R, WR, FIN.
- IDLE:
  - `start` with `num_lines`≠0: latch all three inputs, clear `error` and `lines_done`, assert `program_load_en` and `core_reset`, go to AR.
  - `start` with `num_lines`=0: go directly to FIN; no bus traffic.
- AR:
  - Drive `arvalid`=1 with `araddr` = `host_base` + (idx<<6), 64-bit wrap.
  - Constants: `arlen`=0, `arsize`=3'b110, `arid`=`AXI_ID`.
  - On `arready`, go to R.
- R:
  - Drive `rready`=1.
  - On `rvalid` with `rresp`=0: capture `rdata` into the line buffer and go to WR.
  - On `rvalid` with `rresp`≠0: set `error`, drop `program_load_en`, go to IDLE; `core_reset` stays 1 and `done` does not pulse.
  - `rid` and `rlast` are ignored; only one read is ever outstanding.
- WR:
  - Raise `aw_valid` and `w_valid` together.
  - aw address = `ram_base` + (idx<<6), truncated to RAM_ADDR_WIDTH (wraps).
  - w data = line buffer; strb = all ones.
  - Each valid drops independently on its own handshake; a tracking flag per channel records acceptance.
  - When both channels are accepted (same or different cycles): increment idx and `lines_done`. If idx+1 = `num_lines` go to FIN, else go to AR.
- FIN:
  - `program_load_en`=0, `core_reset`=1, `done`=1 for exactly this cycle.
  - Next cycle: IDLE with `core_reset`=0.
- `start` while busy is ignored.
- `program_load_en` never rises while `core_reset` is low.

## Timing
- Reset values: state IDLE; `arvalid`, `rready`, `aw_valid`, `w_valid`, `program_load_en`, `busy`, `done`, `error` all 0; `lines_done` 0; `core_reset` 1.
- Synchronous reset mid-load aborts immediately: next cycle all valids are 0, `core_reset`=1, and no handshake completes.
- Outputs are registered. `arvalid`, `aw_valid` and `w_valid` never drop before their ready is seen, and their payloads are stable while valid.
- With all readies tied high, each line takes 3 cycles (AR, R, WR). Start sampled at cycle 0 → FIN at cycle 3N+1 → `core_reset` low from cycle 3N+2.
- `busy` is high from cycle 1 through FIN inclusive.
- idx counter is LEN_WIDTH bits; `num_lines`=2^LEN_WIDTH−1 completes with no overflow.

## Test plan
- N=1, host_base=0x1000, ram_base=0x40, readies high → araddr=0x1000, aw addr=0x40, data copied, strb all ones, `done` at cycle 4, `core_reset` low at cycle 5.
- N=4 with random stalls on `arready`, `rvalid`, `aw_ready` and `w_ready` (including aw accepted 3 cycles before w) → 4 writes at 0x0, 0x40, 0x80, 0xC0 in order, payloads held stable while stalled, `lines_done`=4.
- Line 2 of N=3 returns `rresp`=2'b10 → `error`=1, `lines_done`=1, `program_load_en` falls, `core_reset` stays 1, no `done`; the next `start` clears `error`.
- `num_lines`=0 → no arvalid or aw_valid, FIN at cycle 1, `done` pulse, `core_reset` low at cycle 2.
- ram_base=0x7FC0 with N=2 → second aw addr wraps to 0x0000.
- `rst` asserted while in WR with `w_valid` high → next cycle all valids 0, IDLE, `core_reset`=1; `start` held high during busy causes no restart.
